csa_sub32_pipe: RTL

- Two-stage pipelined 32-bit carry-select subtractor: computes diff = a - b as a + ~b + 1.
- Serves as the subtraction counterpart to the combinational 32-bit carry-select adder in the convolution datapath, e.g. for the error and offset terms of the filter.
- Valid/ready handshake on both sides; reports unsigned borrow and signed overflow per result.

---
 rtl/csa_sub32_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csa_sub32_pipe.sv
// Two-stage pipelined carry-select subtractor (diff = a + ~b + 1) with valid/ready handshakes.
// Optional macro CSA_SUB_SAT_EN adds the sat_signed port and saturating results in stage 2.
`timescale 1ns/1ps
module csa_sub32_pipe #(
   parameter int WIDTH = 32,
   parameter int SPLIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef CSA_SUB_SAT_EN
   input  logic             sat_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int HW = WIDTH - SPLIT;
   localparam logic [SPLIT:0] LO_ONE = {{SPLIT{1'b0}}, 1'b1};
   localparam logic [HW:0]    HI_ONE = {{HW{1'b0}}, 1'b1};

   logic             s1_valid_r;
   logic             s2_valid_r;
   logic             s1_load_s;
   logic             s2_load_s;
   logic [SPLIT-1:0] lo_r;
   logic             c_lo_r;
   logic [HW:0]      hi0_r;
   logic [HW:0]      hi1_r;
   logic             a_msb_r;
   logic             b_msb_r;
`ifdef CSA_SUB_SAT_EN
   logic             sat_signed_r;
`endif
   logic [SPLIT:0]   lo_sum_s;
   logic [HW:0]      hi0_sum_s;
   logic [HW:0]      hi1_sum_s;
   logic [HW-1:0]    high_s;
   logic             cf_s;
   logic [WIDTH-1:0] wrap_s;
   logic             ovf_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             ovf_r;

   assign s2_load_s = !s2_valid_r || out_ready;
   assign s1_load_s = !s1_valid_r || s2_load_s;
   assign in_ready  = !s1_valid_r || !s2_valid_r || out_ready;
   assign out_valid = s2_valid_r;
   assign diff      = diff_r;
   assign borrow    = borrow_r;
   assign ovf       = ovf_r;

   // Stage 1 adders: low block with carry-in 1, high block speculated for both carry-ins
   always_comb begin
      lo_sum_s  = {1'b0, a[SPLIT-1:0]} + {1'b0, ~b[SPLIT-1:0]} + LO_ONE;
      hi0_sum_s = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, ~b[WIDTH-1:SPLIT]};
      hi1_sum_s = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, ~b[WIDTH-1:SPLIT]} + HI_ONE;
   end

   // Stage 1 registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r   <= 1'b0;
         lo_r         <= {SPLIT{1'b0}};
         c_lo_r       <= 1'b0;
         hi0_r        <= {(HW+1){1'b0}};
         hi1_r        <= {(HW+1){1'b0}};
         a_msb_r      <= 1'b0;
         b_msb_r      <= 1'b0;
`ifdef CSA_SUB_SAT_EN
         sat_signed_r <= 1'b0;
`endif
      end else if (s1_load_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            lo_r         <= lo_sum_s[SPLIT-1:0];
            c_lo_r       <= lo_sum_s[SPLIT];
            hi0_r        <= hi0_sum_s;
            hi1_r        <= hi1_sum_s;
            a_msb_r      <= a[WIDTH-1];
            b_msb_r      <= b[WIDTH-1];
`ifdef CSA_SUB_SAT_EN
            sat_signed_r <= sat_signed;
`endif
         end
      end
   end

   // Stage 2 carry select, overflow and optional saturation
   always_comb begin
      if (c_lo_r) begin
         high_s = hi1_r[HW-1:0];
         cf_s   = hi1_r[HW];
      end else begin
         high_s = hi0_r[HW-1:0];
         cf_s   = hi0_r[HW];
      end
      wrap_s = {high_s, lo_r};
      ovf_s  = (a_msb_r != b_msb_r) && (wrap_s[WIDTH-1] != a_msb_r);
      diff_s = wrap_s;
`ifdef CSA_SUB_SAT_EN
      if (sat_signed_r) begin
         if (ovf_s) begin
            if (a_msb_r) begin
               diff_s = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
               diff_s = {1'b0, {(WIDTH-1){1'b1}}};
            end
         end else begin
            diff_s = wrap_s;
         end
      end else begin
         if (!cf_s) begin
            diff_s = {WIDTH{1'b0}};
         end else begin
            diff_s = wrap_s;
         end
      end
`endif
   end

   // Stage 2 output registers; data holds while stalled or drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         diff_r     <= {WIDTH{1'b0}};
         borrow_r   <= 1'b0;
         ovf_r      <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            diff_r   <= diff_s;
            borrow_r <= !cf_s;
            ovf_r    <= ovf_s;
         end
      end
   end

endmodule
